pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: REG_W, 5, register-address width.
REQ-002 Parameter: CNT_W, 16, stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 IF_IDvalid  in  1  the IF/ID register holds a real instruction.
REQ-006 IF_IDrs1, IF_IDrs2  in  REG_W  source registers of the decoding instruction.
REQ-007 IF_IDuseRs1, IF_IDuseRs2  in  1  the instruction actually reads rs1 / rs2.
REQ-008 IF_IDrd  in  REG_W  destination register of the decoding instruction.
REQ-009 IF_IDregWrite, IF_IDmemRead  in  1  decoded control bits.
REQ-010 branchTaken  in  1  branch or jump resolved taken in EX this cycle.
REQ-011 ID_EXrs1, ID_EXrs2, ID_EXrd  out  REG_W  tracked ID/EX fields; these feed the forwarding unit.
REQ-012 ID_EXregWrite, ID_EXmemRead  out  1  tracked ID/EX control bits.
REQ-013 EX_MEMrd, MEM_WBrd  out  REG_W  tracked destinations for the forwarding unit.
REQ-014 EX_MEMregWrite, MEM_WBregWrite  out  1  tracked write enables for the forwarding unit.
REQ-015 PCwrite, IF_IDwrite  out  1  low means hold the PC / IF/ID register.
REQ-016 flushIF_ID  out  1  high means replace IF/ID with a bubble at the next edge.
REQ-017 hazState  out  2  registered state: 0 RUN, 1 LOAD_STALL, 2 FLUSH.
REQ-018 stallCount  out  CNT_W  number of load-use stall cycles since reset.

Function
REQ-019 loadUse (combinational) SHALL be true exactly when all of these hold:
  - IF_IDvalid and ID_EXmemRead are high.
  - ID_EXrd is not 0.
  - useRs1 is high and ID_EXrd equals IF_IDrs1, or useRs2 is high and ID_EXrd equals IF_IDrs2.
REQ-020 When branchTaken is high:
  - flushIF_ID = 1; PCwrite = 1; IF_IDwrite = 1.
  - At the next edge the ID/EX stage loads a bubble.
  - branchTaken takes priority over loadUse in the same cycle.
REQ-021 Otherwise, when loadUse is high:
  - PCwrite = 0; IF_IDwrite = 0; flushIF_ID = 0.
  - At the next edge the ID/EX stage loads a bubble.
REQ-022 Otherwise: PCwrite = 1, IF_IDwrite = 1, flushIF_ID = 0, and at the next edge the ID/EX stage loads the IF_ID fields.
  - regWrite and memRead are loaded gated by IF_IDvalid.
REQ-023 Bubble contents: rs1 = rs2 = rd = 0; regWrite = 0; memRead = 0.
REQ-024 EX_MEMrd/EX_MEMregWrite SHALL load ID_EXrd/ID_EXregWrite at every edge, with no stall or flush gating.
REQ-025 MEM_WBrd/MEM_WBregWrite SHALL load EX_MEMrd/EX_MEMregWrite at every edge.
REQ-026 A load-use stall SHALL last exactly 1 cycle, because the inserted bubble clears ID_EXmemRead.
REQ-027 hazState next-state rules:
  - FLUSH if branchTaken.
  - else LOAD_STALL if loadUse.
  - else RUN.
REQ-028 stallCount SHALL increment by 1 on each edge where loadUse is high and branchTaken is low.
  - It saturates at all-ones and does not wrap.
REQ-029 A writer with rd = 0 SHALL never cause a stall.
REQ-030 The stall, flush and write-enable outputs are combinational from the inputs and current state. Pipeline-tracking outputs and hazState are registered.

Reset
REQ-031 While reset_n is low, all of the following SHALL be 0 asynchronously:
  - all ID_EX, EX_MEM and MEM_WB fields;
  - stallCount;
  - hazState (RUN).
REQ-032 During reset, PCwrite = 0, IF_IDwrite = 0, flushIF_ID = 1.
REQ-033 Deassertion mid-operation SHALL restart from the empty pipeline, with no stall on the first cycle.

Structure
REQ-034 A shared pipeline package SHALL hold:
  - REG_W;
  - the hazState encoding constants (RUN, LOAD_STALL, FLUSH);
  - the bubble field values.
REQ-035 One sub-module, pipe_track_reg, SHALL implement one rd/regWrite tracking stage and be instantiated twice (EX_MEM and MEM_WB). The rest stays flat.

Verification
REQ-036 Load-use on rs1:
  - Stimulus: lw x5 in ID/EX, then add reading x5 via rs1 (useRs1 = 1).
  - Response: PCwrite = 0 for exactly 1 cycle, next ID_EXrd = 0, stallCount = 1, and EX_MEMrd = 5 one cycle later.
REQ-037 No stall on x0:
  - Stimulus: lw x0 followed by a reader of x0.
  - Response: no stall, stallCount remains 0.
REQ-038 Unused source:
  - Stimulus: lw x7 followed by an instruction with rs2 = 7 but useRs2 = 0.
  - Response: no stall.
REQ-039 Branch with load-use in the same cycle:
  - Response: flushIF_ID = 1, PCwrite = 1, ID/EX bubble, hazState = FLUSH, stallCount unchanged.
REQ-040 Pipeline tracking and saturation:
  - Stimulus: sequence rd = 3, 4, 6 with regWrite = 1.
  - Response: MEM_WBrd = 3 at cycle 3; stallCount forced near 16'hFFFF saturates at 16'hFFFF.
REQ-041 Reset mid-operation:
  - Stimulus: reset_n pulsed low mid-stream.
  - Response: all tracked fields go to 0 immediately; after release, the first instruction passes without a stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline widths, hazard state encoding and bubble field values
package pipe_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } haz_state_t;
  localparam int   BUBBLE_REG       = 0;
  localparam logic BUBBLE_REG_WRITE = 1'b0;
  localparam logic BUBBLE_MEM_READ  = 1'b0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode-stage inputs plus tracked pipeline fields and hazard controls
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             IF_IDvalid;
  logic [REG_W-1:0] IF_IDrs1;
  logic [REG_W-1:0] IF_IDrs2;
  logic             IF_IDuseRs1;
  logic             IF_IDuseRs2;
  logic [REG_W-1:0] IF_IDrd;
  logic             IF_IDregWrite;
  logic             IF_IDmemRead;
  logic             branchTaken;
  logic [REG_W-1:0] ID_EXrs1;
  logic [REG_W-1:0] ID_EXrs2;
  logic [REG_W-1:0] ID_EXrd;
  logic             ID_EXregWrite;
  logic             ID_EXmemRead;
  logic [REG_W-1:0] EX_MEMrd;
  logic             EX_MEMregWrite;
  logic [REG_W-1:0] MEM_WBrd;
  logic             MEM_WBregWrite;
  logic             PCwrite;
  logic             IF_IDwrite;
  logic             flushIF_ID;
  logic [1:0]       hazState;
  logic [CNT_W-1:0] stallCount;
  modport master (
    output IF_IDvalid, IF_IDrs1, IF_IDrs2, IF_IDuseRs1, IF_IDuseRs2, IF_IDrd,
           IF_IDregWrite, IF_IDmemRead, branchTaken,
    input  ID_EXrs1, ID_EXrs2, ID_EXrd, ID_EXregWrite, ID_EXmemRead,
           EX_MEMrd, EX_MEMregWrite, MEM_WBrd, MEM_WBregWrite,
           PCwrite, IF_IDwrite, flushIF_ID, hazState, stallCount
  );
  modport slave (
    input  IF_IDvalid, IF_IDrs1, IF_IDrs2, IF_IDuseRs1, IF_IDuseRs2, IF_IDrd,
           IF_IDregWrite, IF_IDmemRead, branchTaken,
    output ID_EXrs1, ID_EXrs2, ID_EXrd, ID_EXregWrite, ID_EXmemRead,
           EX_MEMrd, EX_MEMregWrite, MEM_WBrd, MEM_WBregWrite,
           PCwrite, IF_IDwrite, flushIF_ID, hazState, stallCount
  );
endinterface

// File: rtl/pipe_track_reg.sv
// pipe_track_reg: one rd/regWrite tracking stage for the forwarding unit
module pipe_track_reg #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_reg_write,
  output logic [REG_W-1:0] q_rd,
  output logic             q_reg_write
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_rd        <= '0;
      q_reg_write <= 1'b0;
    end else begin
      q_rd        <= d_rd;
      q_reg_write <= d_reg_write;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall / branch flush control with ID/EX, EX/MEM, MEM/WB tracking
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = pipe_hazard_ctrl_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset_n,
  pipe_hazard_ctrl_if.slave bus
);
  haz_state_t state, state_nxt;
  logic       load_use;
  logic       bubble;
  assign load_use = bus.IF_IDvalid && bus.ID_EXmemRead && (bus.ID_EXrd != '0) &&
                    ((bus.IF_IDuseRs1 && (bus.ID_EXrd == bus.IF_IDrs1)) ||
                     (bus.IF_IDuseRs2 && (bus.ID_EXrd == bus.IF_IDrs2)));
  always_comb begin
    state_nxt = bus.branchTaken ? FLUSH : load_use ? LOAD_STALL : RUN;
    bubble    = bus.branchTaken || load_use;
  end
  // a taken branch overrides the stall: the dependent instruction is being squashed anyway
  assign bus.PCwrite    = reset_n && (bus.branchTaken || !load_use);
  assign bus.IF_IDwrite = reset_n && (bus.branchTaken || !load_use);
  assign bus.flushIF_ID = !reset_n || bus.branchTaken;
  assign bus.hazState   = state;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ID_EXrs1      <= '0;
      bus.ID_EXrs2      <= '0;
      bus.ID_EXrd       <= '0;
      bus.ID_EXregWrite <= 1'b0;
      bus.ID_EXmemRead  <= 1'b0;
    end else if (bubble) begin
      bus.ID_EXrs1      <= REG_W'(BUBBLE_REG);
      bus.ID_EXrs2      <= REG_W'(BUBBLE_REG);
      bus.ID_EXrd       <= REG_W'(BUBBLE_REG);
      bus.ID_EXregWrite <= BUBBLE_REG_WRITE;
      bus.ID_EXmemRead  <= BUBBLE_MEM_READ;
    end else begin
      bus.ID_EXrs1      <= bus.IF_IDrs1;
      bus.ID_EXrs2      <= bus.IF_IDrs2;
      bus.ID_EXrd       <= bus.IF_IDrd;
      bus.ID_EXregWrite <= bus.IF_IDregWrite && bus.IF_IDvalid;
      bus.ID_EXmemRead  <= bus.IF_IDmemRead && bus.IF_IDvalid;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      bus.stallCount <= '0;
    end else begin
      state <= state_nxt;
      if (load_use && !bus.branchTaken && (bus.stallCount != '1))
        bus.stallCount <= bus.stallCount + CNT_W'(1);
    end
  end
  pipe_track_reg #(.REG_W(REG_W)) u_ex_mem (
    .clk         (clk),
    .reset_n     (reset_n),
    .d_rd        (bus.ID_EXrd),
    .d_reg_write (bus.ID_EXregWrite),
    .q_rd        (bus.EX_MEMrd),
    .q_reg_write (bus.EX_MEMregWrite)
  );
  pipe_track_reg #(.REG_W(REG_W)) u_mem_wb (
    .clk         (clk),
    .reset_n     (reset_n),
    .d_rd        (bus.EX_MEMrd),
    .d_reg_write (bus.EX_MEMregWrite),
    .q_rd        (bus.MEM_WBrd),
    .q_reg_write (bus.MEM_WBregWrite)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed hazard scenarios with hand-computed expectations
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(2))  sbus ();
  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(2))  dut_sat (.clk(clk), .reset_n(reset_n), .bus(sbus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic br);
    bus.IF_IDvalid    = v;
    bus.IF_IDrs1      = r1;
    bus.IF_IDrs2      = r2;
    bus.IF_IDuseRs1   = u1;
    bus.IF_IDuseRs2   = u2;
    bus.IF_IDrd       = rd;
    bus.IF_IDregWrite = rw;
    bus.IF_IDmemRead  = mr;
    bus.branchTaken   = br;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sbus.IF_IDvalid = 0; sbus.IF_IDrs1 = 0; sbus.IF_IDrs2 = 0; sbus.IF_IDuseRs1 = 0;
    sbus.IF_IDuseRs2 = 0; sbus.IF_IDrd = 0; sbus.IF_IDregWrite = 0; sbus.IF_IDmemRead = 0;
    sbus.branchTaken = 0;
    repeat (2) @(negedge clk);
    chk("rst_pcwrite", bus.PCwrite, 0);
    chk("rst_ifidwrite", bus.IF_IDwrite, 0);
    chk("rst_flush", bus.flushIF_ID, 1);
    chk("rst_state", bus.hazState, 0);
    chk("rst_count", bus.stallCount, 0);
    chk("rst_idex_rd", bus.ID_EXrd, 0);
    reset_n = 1'b1;
    tick();
    // lw x0 then a reader of x0: never stalls
    drv(1, 1, 2, 0, 0, 0, 1, 1, 0);
    tick();
    chk("x0_idex_memread", bus.ID_EXmemRead, 1);
    drv(1, 0, 0, 1, 1, 9, 1, 0, 0);
    #3;
    chk("x0_pcwrite", bus.PCwrite, 1);
    tick();
    chk("x0_count", bus.stallCount, 0);
    chk("x0_idex_rd", bus.ID_EXrd, 9);
    // lw x7 then rs2=7 with useRs2=0: no stall
    drv(1, 1, 2, 0, 0, 7, 1, 1, 0);
    tick();
    drv(1, 1, 7, 1, 0, 10, 1, 0, 0);
    #3;
    chk("unused_pcwrite", bus.PCwrite, 1);
    tick();
    chk("unused_idex_rd", bus.ID_EXrd, 10);
    chk("unused_state", bus.hazState, 0);
    chk("unused_count", bus.stallCount, 0);
    // lw x5 then add reading x5 via rs1: one-cycle stall
    drv(1, 1, 2, 0, 0, 5, 1, 1, 0);
    #3;
    chk("lu_pre_pcwrite", bus.PCwrite, 1);
    tick();
    chk("lu_idex_rd", bus.ID_EXrd, 5);
    chk("lu_state_run", bus.hazState, 0);
    drv(1, 5, 3, 1, 0, 8, 1, 0, 0);
    #3;
    chk("lu_pcwrite", bus.PCwrite, 0);
    chk("lu_ifidwrite", bus.IF_IDwrite, 0);
    chk("lu_flush", bus.flushIF_ID, 0);
    tick();
    chk("lu_bubble_rd", bus.ID_EXrd, 0);
    chk("lu_bubble_memread", bus.ID_EXmemRead, 0);
    chk("lu_count", bus.stallCount, 1);
    chk("lu_exmem_rd", bus.EX_MEMrd, 5);
    chk("lu_state_stall", bus.hazState, 1);
    #3;
    chk("lu_release_pcwrite", bus.PCwrite, 1);
    tick();
    chk("lu_after_idex_rd", bus.ID_EXrd, 8);
    chk("lu_after_memwb_rd", bus.MEM_WBrd, 5);
    chk("lu_after_state", bus.hazState, 0);
    chk("lu_after_count", bus.stallCount, 1);
    // branch taken in the same cycle as a load-use
    drv(1, 1, 2, 0, 0, 11, 1, 1, 0);
    tick();
    drv(1, 11, 0, 1, 0, 12, 1, 0, 1);
    #3;
    chk("br_flush", bus.flushIF_ID, 1);
    chk("br_pcwrite", bus.PCwrite, 1);
    chk("br_ifidwrite", bus.IF_IDwrite, 1);
    tick();
    chk("br_bubble_rd", bus.ID_EXrd, 0);
    chk("br_bubble_regwrite", bus.ID_EXregWrite, 0);
    chk("br_state", bus.hazState, 2);
    chk("br_count", bus.stallCount, 1);
    chk("br_exmem_rd", bus.EX_MEMrd, 11);
    // invalid IF/ID: rd loads but regWrite is gated off
    drv(0, 0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    chk("inv_state", bus.hazState, 0);
    chk("inv_idex_rd", bus.ID_EXrd, 5);
    chk("inv_idex_regwrite", bus.ID_EXregWrite, 0);
    chk("inv_idex_memread", bus.ID_EXmemRead, 0);
    // tracking rd = 3, 4, 6
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    chk("trk_idex_rd", bus.ID_EXrd, 3);
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0);
    tick();
    chk("trk_exmem_rd", bus.EX_MEMrd, 3);
    drv(1, 0, 0, 0, 0, 6, 1, 0, 0);
    tick();
    chk("trk_memwb_rd", bus.MEM_WBrd, 3);
    chk("trk_memwb_rw", bus.MEM_WBregWrite, 1);
    chk("trk_exmem_rd2", bus.EX_MEMrd, 4);
    chk("trk_idex_rd2", bus.ID_EXrd, 6);
    // reset pulse mid-stream, away from the clock edge
    #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_idex_rd", bus.ID_EXrd, 0);
    chk("mrst_exmem_rd", bus.EX_MEMrd, 0);
    chk("mrst_memwb_rd", bus.MEM_WBrd, 0);
    chk("mrst_memwb_rw", bus.MEM_WBregWrite, 0);
    chk("mrst_count", bus.stallCount, 0);
    chk("mrst_pcwrite", bus.PCwrite, 0);
    chk("mrst_flush", bus.flushIF_ID, 1);
    #1;
    reset_n = 1'b1;
    drv(1, 5, 5, 1, 1, 13, 1, 1, 0);
    #1;
    chk("post_rst_pcwrite", bus.PCwrite, 1);
    tick();
    chk("post_rst_idex_rd", bus.ID_EXrd, 13);
    chk("post_rst_state", bus.hazState, 0);
    chk("post_rst_count", bus.stallCount, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // saturation on a 2-bit counter: a self-dependent load stalls every other cycle
    sbus.IF_IDvalid = 1; sbus.IF_IDrs1 = 5; sbus.IF_IDuseRs1 = 1;
    sbus.IF_IDrd = 5; sbus.IF_IDregWrite = 1; sbus.IF_IDmemRead = 1;
    repeat (4) tick();
    chk("sat_count2", sbus.stallCount, 2);
    chk("sat_state", sbus.hazState, 1);
    repeat (2) tick();
    chk("sat_count3", sbus.stallCount, 3);
    repeat (4) tick();
    chk("sat_hold", sbus.stallCount, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
